lcd_bus_receiver: RTL and testbench
===================================

Name: lcd_bus_receiver

Overview:
- Receiving end of the HD44780-style 4-bit character LCD bus that our LCD_driver-class blocks transmit on.
- Snoops RS/W/E/b3..b0 and decodes the 4-bit/8-bit instruction set.
- Maintains a 2x16 DDRAM shadow, presented as two 128-bit packed lines in the same format the transmitter accepts.
- Used as an on-chip loopback checker and as a simulation display model.

Parameters:
- SYNC_STAGES, 2: flop stages on every bus input (E, RS, W, b3..b0 all equally delayed).
- EXEC_CYCLES, 3700: minimum clk cycles between bytes for ordinary instructions/data (optional checker only).
- CLEAR_CYCLES, 152000: minimum clk cycles after clear/home (optional checker only).

Ports:
- clk  in  1  system clock, single domain.
- rst_n  in  1  asynchronous active-low reset.
- LCD_RS  in  1  register select: 0 = instruction, 1 = data.
- LCD_W  in  1  R/W: 0 = write, 1 = read.
- LCD_E  in  1  enable strobe; latched on falling edge.
- b3, b2, b1, b0  in  1 each  data nibble, b3 = MSB.
- line1  out  128  row 0 chars, char 0 at [127:120].
- line2  out  128  row 1 chars, same packing.
- mode_4bit  out  1  current interface width is 4-bit.
- two_line  out  1  N bit from the last function set.
- disp_on  out  1  D bit from the last display control.
- byte_vld  out  1  one-cycle pulse per completed write byte.
- byte_out  out  8  the completed byte; valid with byte_vld.
- byte_rs  out  1  RS of the completed byte.
- timing_err  out  1  sticky; only with LCD_TIMING_CHK_EN.

Behaviour:
- Reset values:
  - line1 and line2 = {16{8'h20}}.
  - mode_4bit=0, two_line=0, disp_on=0, byte_vld=0, byte_out=0, byte_rs=0, timing_err=0.
  - Internal state: DDRAM address=0, increment mode (I/D=1), DDRAM target, nibble phase=0, synchronizer flops=0.
- E fall is detected when the delayed synchronized E is 1 and the synchronized E is 0.
- RS/W/nibble are taken from the synchronized copies in the detect cycle.
- All effects (buffer, flags, byte_vld) are visible at the clk edge ending the detect cycle.
- Total latency: SYNC_STAGES+1 edges after the first edge that samples LCD_E low.
- Byte assembly:
  - 8-bit mode: each fall is one byte = {nibble, 4'h0}.
  - 4-bit mode, phase 0: store the high nibble, go to phase 1.
  - 4-bit mode, phase 1: byte = {high, nibble}, go to phase 0.
- Reads (W=1) advance the phase identically but produce no byte_vld and no effect.
- Instruction decode (RS=0), by highest set bit:
  - 0x01 clear: both lines = 0x20, addr=0, I/D=1, target DDRAM.
  - 0x02/03 home: addr=0.
  - 0x04-07: I/D = bit1; shift bit ignored.
  - 0x08-0F: disp_on = bit2.
  - 0x10-1F: if bit3=0, step addr in direction bit2 (1 = right/inc, 0 = left/dec) using the wrap rules below; bit3=1 is ignored.
  - 0x20-3F: mode_4bit = ~bit4, two_line = bit3, phase forced to 0.
  - 0x40-7F: target CGRAM; subsequent data is discarded and addr is not modified.
  - 0x80-FF: addr = byte[6:0], target DDRAM.
- Data (RS=1), target DDRAM:
  - addr 0x00-0x0F writes line1 char addr.
  - addr 0x40-0x4F writes line2 char addr-0x40.
  - Other addresses are off-screen; the write is discarded but addr still steps per I/D.
- Address wrap:
  - inc: 0x27->0x40, 0x67->0x00.
  - dec: 0x00->0x67, 0x40->0x27.
  - An illegal address set (0x28-0x3F, 0x68-0x7F) is held; the next inc goes to 0x40 or 0x00 respectively.
- Simultaneous events: clear, data write and addr step are one atomic update per byte; no two bytes complete in the same cycle.
- Reset mid-byte: the pending high nibble is lost; phase=0, mode=8-bit.
- Resync: 3,3,3,2 from any phase ends in 4-bit mode, phase 0.

Optional Feature:
- Macro LCD_TIMING_CHK_EN.
- When defined:
  - A counter restarts on every completed byte (write or read).
  - The restarted counter loads CLEAR_CYCLES after clear/home and EXEC_CYCLES otherwise.
  - An E fall while the counter is nonzero sets timing_err, cleared only by reset.
  - The byte is still processed.
- When undefined: the counter is not built; timing_err is tied to 0.

Test Plan:
- Reset, no E activity -> line1=line2={16{8'h20}}; mode_4bit=0, two_line=0, disp_on=0; byte_vld never pulses.
- Nibbles 3,3,3,2,2,8,0,6,0,C,0,1 (RS=0, W=0) -> mode_4bit=1, two_line=1, disp_on=1; lines all 0x20; 8 byte_vld pulses, last byte_out=8'h01.
- After init: 0x80, then "HELLO" as nibble pairs with RS=1 -> line1[127:88]=40'h48454C4C4F, line1 remainder 0x20; last byte_vld has byte_rs=1, byte_out=8'h4F.
- 0xC0 then 17 chars 'A'..'Q' -> line2 = "ABCDEFGHIJKLMNOP"; 'Q' goes to 0x50 and is discarded; line1 unchanged.
- 0xA7 then 'X','Y' -> 'X' discarded (0x27), 'Y' at line2[127:120]=8'h59. Then 0x04 (I/D=0), 0xC0, 'Z' -> 'Z' at line2[127:120], addr wraps to 0x27.
- In 4-bit mode, send high nibble 0x4 then pulse rst_n low -> lines 0x20, mode_4bit=0. With LCD_TIMING_CHK_EN, two bytes 10 cycles apart -> timing_err=1.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// HD44780-style 4/8-bit character LCD bus receiver with a 2x16 DDRAM shadow.
// Optional busy-time checker is built when LCD_TIMING_CHK_EN is defined.
module lcd_bus_receiver #(
  parameter int SYNC_STAGES  = 2,
  parameter int EXEC_CYCLES  = 3700,
  parameter int CLEAR_CYCLES = 152000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         LCD_RS,
  input  logic         LCD_W,
  input  logic         LCD_E,
  input  logic         b3,
  input  logic         b2,
  input  logic         b1,
  input  logic         b0,
  output logic [127:0] line1,
  output logic [127:0] line2,
  output logic         mode_4bit,
  output logic         two_line,
  output logic         disp_on,
  output logic         byte_vld,
  output logic [7:0]   byte_out,
  output logic         byte_rs,
  output logic         timing_err
);

  localparam logic [127:0] BLANK = {16{8'h20}};
  localparam int CMAX = (CLEAR_CYCLES > EXEC_CYCLES) ? CLEAR_CYCLES : EXEC_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  // Handshake: the bus has no ready; a byte is accepted on each detected E fall,
  // and byte_vld/byte_out/byte_rs form a one-cycle valid-only strobe downstream.

  typedef enum logic {PH_HI = 1'b0, PH_LO = 1'b1} phase_t;

  // ---------------------------------------------------------------- synchronizer
  logic [6:0] sync_q [SYNC_STAGES];
  logic [6:0] bus_s;
  logic       e_d_q;
  logic       e_s, rs_s, w_s;
  logic [3:0] nib_s;
  logic       fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      e_d_q <= 1'b0;
    end else begin
      sync_q[0] <= {LCD_E, LCD_RS, LCD_W, b3, b2, b1, b0};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      e_d_q <= bus_s[6];
    end
  end

  assign bus_s = sync_q[SYNC_STAGES-1];
  assign e_s   = bus_s[6];
  assign rs_s  = bus_s[5];
  assign w_s   = bus_s[4];
  assign nib_s = bus_s[3:0];
  assign fall  = e_d_q & ~e_s;

  // ---------------------------------------------------------------- state
  phase_t       phase_q, phase_d;
  logic [3:0]   hi_q;
  logic [6:0]   addr_q, addr_d;
  logic         id_q, id_d;
  logic         cg_q, cg_d;
  logic         mode_q, mode_d;
  logic         two_q, two_d;
  logic         disp_q, disp_d;
  logic [127:0] line1_q, line1_d;
  logic [127:0] line2_q, line2_d;
  logic         vld_q;
  logic [7:0]   out_q;
  logic         rs_q;

  logic         byte_done;
  logic         wr_done;
  logic [7:0]   byte_val;
  logic         is_fset;

  function automatic logic [6:0] addr_inc(input logic [6:0] a);
    if (a >= 7'h27 && a <= 7'h3F) return 7'h40;
    else if (a >= 7'h67)          return 7'h00;
    else                          return a + 7'd1;
  endfunction

  function automatic logic [6:0] addr_dec(input logic [6:0] a);
    if (a == 7'h00)                    return 7'h67;
    else if (a >= 7'h28 && a <= 7'h40) return 7'h27;
    else if (a >= 7'h68)               return 7'h67;
    else                               return a - 7'd1;
  endfunction

  // Phase FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= PH_HI;
    else        phase_q <= phase_d;
  end

  // Phase FSM: next state
  always_comb begin
    phase_d = phase_q;
    if (fall) begin
      if (!mode_q)               phase_d = PH_HI;
      else if (phase_q == PH_HI) phase_d = PH_LO;
      else                       phase_d = PH_HI;
      if (is_fset)               phase_d = PH_HI;
    end
  end

  // Phase FSM: outputs (byte assembly)
  always_comb begin
    byte_done = fall & (~mode_q | (phase_q == PH_LO));
    wr_done   = byte_done & ~w_s;
    byte_val  = mode_q ? {hi_q, nib_s} : {nib_s, 4'h0};
    is_fset   = wr_done & ~rs_s & (byte_val[7:5] == 3'b001);
  end

  // Instruction / data decode: one atomic update per completed write byte.
  always_comb begin
    addr_d  = addr_q;
    id_d    = id_q;
    cg_d    = cg_q;
    mode_d  = mode_q;
    two_d   = two_q;
    disp_d  = disp_q;
    line1_d = line1_q;
    line2_d = line2_q;
    if (wr_done) begin
      if (!rs_s) begin
        casez (byte_val)
          8'b1???????: begin addr_d = byte_val[6:0]; cg_d = 1'b0; end
          8'b01??????: cg_d = 1'b1;
          8'b001?????: begin mode_d = ~byte_val[4]; two_d = byte_val[3]; end
          8'b0001????: if (!byte_val[3]) addr_d = byte_val[2] ? addr_inc(addr_q) : addr_dec(addr_q);
          8'b00001???: disp_d = byte_val[2];
          8'b000001??: id_d = byte_val[1];
          8'b0000001?: addr_d = 7'h00;
          8'b00000001: begin
            line1_d = BLANK;
            line2_d = BLANK;
            addr_d  = 7'h00;
            id_d    = 1'b1;
            cg_d    = 1'b0;
          end
          default: ;
        endcase
      end else if (!cg_q) begin
        // Char n of a line lives at bits [127-8n -: 8], i.e. offset 8*(15-n).
        if (addr_q[6:4] == 3'b000) line1_d[{~addr_q[3:0], 3'b000} +: 8] = byte_val;
        if (addr_q[6:4] == 3'b100) line2_d[{~addr_q[3:0], 3'b000} +: 8] = byte_val;
        addr_d = id_q ? addr_inc(addr_q) : addr_dec(addr_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= 4'h0;
      addr_q  <= 7'h00;
      id_q    <= 1'b1;
      cg_q    <= 1'b0;
      mode_q  <= 1'b0;
      two_q   <= 1'b0;
      disp_q  <= 1'b0;
      line1_q <= BLANK;
      line2_q <= BLANK;
      vld_q   <= 1'b0;
      out_q   <= 8'h00;
      rs_q    <= 1'b0;
    end else begin
      if (fall && mode_q && phase_q == PH_HI) hi_q <= nib_s;
      addr_q  <= addr_d;
      id_q    <= id_d;
      cg_q    <= cg_d;
      mode_q  <= mode_d;
      two_q   <= two_d;
      disp_q  <= disp_d;
      line1_q <= line1_d;
      line2_q <= line2_d;
      vld_q   <= wr_done;
      if (wr_done) begin
        out_q <= byte_val;
        rs_q  <= rs_s;
      end
    end
  end

  assign line1     = line1_q;
  assign line2     = line2_q;
  assign mode_4bit = mode_q;
  assign two_line  = two_q;
  assign disp_on   = disp_q;
  assign byte_vld  = vld_q;
  assign byte_out  = out_q;
  assign byte_rs   = rs_q;

`ifdef LCD_TIMING_CHK_EN
  logic [CW-1:0] busy_q;
  logic          terr_q;
  logic          slow_cmd;

  // Clear and home share the long busy time; reads reload the short one.
  assign slow_cmd = wr_done & ~rs_s & (byte_val[7:2] == 6'b0) & (byte_val[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      terr_q <= 1'b0;
    end else begin
      if (fall && busy_q != '0) terr_q <= 1'b1;
      if (byte_done)            busy_q <= slow_cmd ? CW'(CLEAR_CYCLES) : CW'(EXEC_CYCLES);
      else if (busy_q != '0)    busy_q <= busy_q - 1'b1;
    end
  end

  assign timing_err = terr_q;
`else
  logic [CW-1:0] unused_cfg;
  assign unused_cfg = CW'(EXEC_CYCLES) ^ CW'(CLEAR_CYCLES);
  assign timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: init sequence, text writes, wrap rules,
// CGRAM/read handling, mid-byte reset and the optional busy-time checker.
module tb_lcd_bus_receiver;

  localparam logic [127:0] BLANK = {16{8'h20}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         LCD_RS = 1'b0, LCD_W = 1'b0, LCD_E = 1'b0;
  logic         b3 = 1'b0, b2 = 1'b0, b1 = 1'b0, b0 = 1'b0;
  logic [127:0] line1, line2;
  logic         mode_4bit, two_line, disp_on, byte_vld, byte_rs, timing_err;
  logic [7:0]   byte_out;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int vld_cnt = 0;
  int vld_base;

  lcd_bus_receiver dut (
    .clk(clk), .rst_n(rst_n), .LCD_RS(LCD_RS), .LCD_W(LCD_W), .LCD_E(LCD_E),
    .b3(b3), .b2(b2), .b1(b1), .b0(b0),
    .line1(line1), .line2(line2), .mode_4bit(mode_4bit), .two_line(two_line),
    .disp_on(disp_on), .byte_vld(byte_vld), .byte_out(byte_out),
    .byte_rs(byte_rs), .timing_err(timing_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (byte_vld) vld_cnt++;

  // driver tasks
  task automatic send_nibble(input logic rs, input logic w, input logic [3:0] nib);
    @(negedge clk);
    LCD_RS = rs; LCD_W = w; {b3, b2, b1, b0} = nib; LCD_E = 1'b1;
    repeat (2) @(negedge clk);
    LCD_E = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] val);
    send_nibble(rs, 1'b0, val[7:4]);
    send_nibble(rs, 1'b0, val[3:0]);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(1'b1, s[i]);
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmp_cnt++;
    assert (obs === exp)
    else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // reset state, no bus activity
    check("rst_line1", line1, BLANK);
    check("rst_line2", line2, BLANK);
    check("rst_flags", {mode_4bit, two_line, disp_on}, 3'b000);
    check("rst_byte", {byte_rs, byte_out}, 9'h000);
    check("rst_terr", timing_err, 1'b0);
    check("rst_no_vld", vld_cnt, 0);

    // init: 3,3,3,2 resync then 0x28, 0x06, 0x0C, 0x01
    vld_base = vld_cnt;
    send_nibble(0, 0, 4'h3); send_nibble(0, 0, 4'h3);
    send_nibble(0, 0, 4'h3); send_nibble(0, 0, 4'h2);
    send_byte(0, 8'h28); send_byte(0, 8'h06);
    send_byte(0, 8'h0C); send_byte(0, 8'h01);
    check("init_vld_cnt", vld_cnt - vld_base, 8);
    check("init_flags", {mode_4bit, two_line, disp_on}, 3'b111);
    check("init_last_byte", {byte_rs, byte_out}, 9'h001);
    check("init_line1", line1, BLANK);
    check("init_line2", line2, BLANK);

    // HELLO on line 1
    vld_base = vld_cnt;
    send_byte(0, 8'h80);
    send_str("HELLO");
    check("hello_line1", line1, {40'h48454C4C4F, {11{8'h20}}});
    check("hello_last_byte", {byte_rs, byte_out}, 9'h14F);
    check("hello_vld_cnt", vld_cnt - vld_base, 6);

    // line 2 fill, 17th char lands off-screen at 0x50
    send_byte(0, 8'hC0);
    send_str("ABCDEFGHIJKLMNOPQ");
    check("fill_line2", line2, 128'h4142434445464748494A4B4C4D4E4F50);
    check("fill_line1", line1, {40'h48454C4C4F, {11{8'h20}}});

    // 0x27 -> 0x40 increment wrap
    send_byte(0, 8'hA7);
    send_str("XY");
    check("wrap27_line2", line2, 128'h5942434445464748494A4B4C4D4E4F50);

    // decrement from 0x40 -> 0x27, then increment back to 0x40
    send_byte(0, 8'h04);
    send_byte(0, 8'hC0);
    send_str("Z");
    check("dec40_line2", line2, 128'h5A42434445464748494A4B4C4D4E4F50);
    send_byte(0, 8'h06);
    send_str("VU");
    check("dec40_wrap_line2", line2, 128'h5542434445464748494A4B4C4D4E4F50);

    // decrement from 0x00 -> 0x67, increment 0x67 -> 0x00
    send_byte(0, 8'h04);
    send_byte(0, 8'h80);
    send_str("a");
    send_byte(0, 8'h06);
    send_str("bc");
    check("dec00_line1", line1, {40'h63454C4C4F, {11{8'h20}}});

    // cursor shift right then write
    send_byte(0, 8'h80);
    send_byte(0, 8'h14);
    send_str("e");
    check("shift_line1", line1, {40'h63654C4C4F, {11{8'h20}}});

    // CGRAM target discards data but still strobes the byte
    vld_base = vld_cnt;
    send_byte(0, 8'h40);
    send_byte(1, 8'h77);
    check("cg_vld_cnt", vld_cnt - vld_base, 2);
    check("cg_byte", {byte_rs, byte_out}, 9'h177);
    check("cg_line1", line1, {40'h63654C4C4F, {11{8'h20}}});
    check("cg_line2", line2, 128'h5542434445464748494A4B4C4D4E4F50);

    // display off, reads, display on
    send_byte(0, 8'h80);
    send_byte(0, 8'h08);
    check("disp_off", disp_on, 1'b0);
    vld_base = vld_cnt;
    send_nibble(1, 1, 4'hF); send_nibble(1, 1, 4'hF);
    check("read_no_vld", vld_cnt - vld_base, 0);
    check("read_line1", line1, {40'h63654C4C4F, {11{8'h20}}});
    send_byte(0, 8'h0C);
    check("disp_on_after_read", {disp_on, byte_out}, 9'h10C);
    send_byte(0, 8'h20);
    check("fset_one_line", {mode_4bit, two_line}, 2'b10);

    // reset with a pending high nibble
    send_nibble(1, 0, 4'h4);
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_line1", line1, BLANK);
    check("midrst_line2", line2, BLANK);
    check("midrst_flags", {mode_4bit, two_line, disp_on}, 3'b000);
    check("midrst_terr", timing_err, 1'b0);

    // 8-bit mode after reset: single nibble forms {nib, 0}
    vld_base = vld_cnt;
    send_nibble(0, 0, 4'h8);
    send_nibble(0, 0, 4'h8);
    check("post_rst_vld_cnt", vld_cnt - vld_base, 2);
    check("post_rst_byte", {byte_rs, byte_out}, 9'h080);
`ifdef LCD_TIMING_CHK_EN
    check("timing_err_set", timing_err, 1'b1);
`else
    check("timing_err_tied", timing_err, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    err_cnt++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
